// File: rtl/hyperbus_cs_sequencer_pkg.sv
// Shared types for the HyperBus chip-select sequencer.
// - cs_state_e  : sequencer state encoding
// - cs_timing_t : per-transaction snapshot of the CS timing windows
// Snapshot fields use fixed maximum widths so that the struct can live in
// the package. The sequencer zero-extends its narrower config ports into it.
package hyperbus_cs_sequencer_pkg;

  // Upper bounds for the CntWidth / CsmWidth parameters of the sequencer.
  localparam int unsigned CntMaxW = 8;
  localparam int unsigned CsmMaxW = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    RECOVER
  } cs_state_e;

  typedef struct packed {
    logic [CntMaxW-1:0] css;
    logic [CntMaxW-1:0] csh;
    logic [CntMaxW-1:0] cshi;
    logic [CsmMaxW-1:0] csm;
  } cs_timing_t;

endpackage

// File: rtl/hyperbus_cs_sequencer_if.sv
// Request/control bundle between the HyperBus controller and the CS sequencer.
// master (controller): drives req_valid, req_cs, close, abort; sees req_ready.
// slave  (sequencer) : the reverse.
//   req_valid  open-transaction request
//   req_ready  request accepted when req_valid & req_ready
//   req_cs     one-hot target chip
//   close      end-of-transaction pulse
//   abort      immediate abort, any state
interface hyperbus_cs_sequencer_if #(
  parameter int unsigned NumChips = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [NumChips-1:0] req_cs;
  logic                close;
  logic                abort;

  modport master (
    output req_valid,
    output req_cs,
    output close,
    output abort,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_cs,
    input  close,
    input  abort,
    output req_ready
  );
endinterface

// File: rtl/hyperbus_cs_sequencer_cnt.sv
// Loadable down-counter used to time the SETUP, HOLD and RECOVER windows.
// Ports:
//   tx_clk_90  clock
//   rst_ni     asynchronous active-low reset
//   load_i     load val_i this edge (takes priority over counting)
//   val_i      window length minus 1
//   done_o     counter has reached zero (last cycle of the window)
module hyperbus_cs_sequencer_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             tx_clk_90,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hyperbus_cs_sequencer.sv
// HyperBus chip-select sequencer (tx_clk_90 domain).
// Drives NumChips active-low chip selects and gates the differential-clock
// enable with programmable t_CSS / t_CSH / t_CSHI windows, plus abort and a
// maximum CS-low (t_CSM) limit.
// Ports:
//   tx_clk_90, rst_ni     clock, asynchronous active-low reset
//   cfg_t_css_i           CS-low-to-first-clock cycles minus 1
//   cfg_t_csh_i           last-clock-to-CS-high cycles minus 1
//   cfg_t_cshi_i          min CS-high time between transactions, minus 1
//   cfg_t_csm_i           max ACTIVE cycles, 0 disables the limit
//   req_if (slave)        req_valid/req_ready/req_cs/close/abort
//   ck_ena_i / ck_ena_o   clock-toggle request / registered clock enable
//   hyper_cs_no           active-low chip selects
//   cs_idx_o              binary index of the open chip
//   active_o              sequencer in ACTIVE
//   cs_err_o              1-cycle pulse: accepted req_cs not one-hot
//   csm_expired_o         1-cycle pulse: t_CSM limit forced the close
// All outputs are registered except req_ready (= IDLE and no abort).
module hyperbus_cs_sequencer
  import hyperbus_cs_sequencer_pkg::*;
#(
  parameter int unsigned NumChips = 2,
  parameter int unsigned CntWidth = 4,   // must not exceed CntMaxW
  parameter int unsigned CsmWidth = 16,  // must not exceed CsmMaxW
  localparam int unsigned IdxW = (NumChips > 1) ? $clog2(NumChips) : 1
) (
  input  logic                tx_clk_90,
  input  logic                rst_ni,
  input  logic [CntWidth-1:0] cfg_t_css_i,
  input  logic [CntWidth-1:0] cfg_t_csh_i,
  input  logic [CntWidth-1:0] cfg_t_cshi_i,
  input  logic [CsmWidth-1:0] cfg_t_csm_i,
  hyperbus_cs_sequencer_if.slave req_if,
  input  logic                ck_ena_i,
  output logic                ck_ena_o,
  output logic [NumChips-1:0] hyper_cs_no,
  output logic [IdxW-1:0]     cs_idx_o,
  output logic                active_o,
  output logic                cs_err_o,
  output logic                csm_expired_o
);

  cs_state_e           state_q, state_d;
  cs_timing_t          timing_q, timing_d;
  logic [NumChips-1:0] cs_sel_q, cs_sel_d;
  logic [NumChips-1:0] cs_no_q, cs_no_d;
  logic [IdxW-1:0]     cs_idx_q, cs_idx_d, req_idx;
  logic [CsmWidth-1:0] csm_cnt_q, csm_cnt_d;
  logic                ck_ena_q, ck_ena_d;
  logic                active_q, active_d;
  logic                cs_err_q, cs_err_d;
  logic                csm_exp_q, csm_exp_d;
  logic                close_pend_q, close_pend_d;
  logic                accept, onehot, close_eff, abort_busy, csm_hit;
  logic                cnt_load, cnt_done;
  logic [CntMaxW-1:0]  cnt_val;
  int unsigned         ones;

  // Abort in IDLE blocks the handshake for that cycle.
  assign req_if.req_ready = (state_q == IDLE) && !req_if.abort;
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign abort_busy       = req_if.abort && (state_q != IDLE);
  // A close seen during SETUP is remembered and consumed in the first ACTIVE cycle.
  assign close_eff        = req_if.close || close_pend_q;
  assign csm_hit          = (timing_q.csm != '0) &&
                            (timing_q.csm == CsmMaxW'(csm_cnt_q));

  // One-hot check and binary index of the requested chip.
  always_comb begin
    ones    = 0;
    req_idx = '0;
    for (int unsigned i = 0; i < NumChips; i++) begin
      if (req_if.req_cs[i]) begin
        ones    = ones + 1;
        req_idx = IdxW'(i);
      end
    end
    onehot = (ones == 1);
  end

  // Next-state logic, including snapshot, close latch, CSM counter and the
  // shared window counter (reloaded on every state entry and on abort).
  always_comb begin
    state_d      = state_q;
    timing_d     = timing_q;
    cs_sel_d     = cs_sel_q;
    close_pend_d = close_pend_q;
    csm_cnt_d    = csm_cnt_q;

    if (accept) begin
      timing_d.css  = CntMaxW'(cfg_t_css_i);
      timing_d.csh  = CntMaxW'(cfg_t_csh_i);
      timing_d.cshi = CntMaxW'(cfg_t_cshi_i);
      timing_d.csm  = CsmMaxW'(cfg_t_csm_i);
      cs_sel_d      = req_if.req_cs;
    end

    case (state_q)
      IDLE:    if (accept && onehot) state_d = SETUP;
      SETUP:   if (abort_busy) state_d = RECOVER;
               else if (cnt_done) state_d = ACTIVE;
      ACTIVE:  if (abort_busy) state_d = RECOVER;
               else if (close_eff || csm_hit) state_d = HOLD;
      HOLD:    if (abort_busy || cnt_done) state_d = RECOVER;
      RECOVER: if (!abort_busy && cnt_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == SETUP) && req_if.close) close_pend_d = 1'b1;
    if ((state_d != SETUP) && (state_d != ACTIVE)) close_pend_d = 1'b0;

    // Counts ACTIVE cycles starting at 1; saturates instead of wrapping.
    if ((state_d == ACTIVE) && (state_q != ACTIVE)) begin
      csm_cnt_d = CsmWidth'(1);
    end else if ((state_q == ACTIVE) && (csm_cnt_q != '1)) begin
      csm_cnt_d = csm_cnt_q + CsmWidth'(1);
    end

    cnt_load = abort_busy || (state_d != state_q);
    case (state_d)
      SETUP:   cnt_val = timing_d.css;
      HOLD:    cnt_val = timing_d.csh;
      RECOVER: cnt_val = timing_d.cshi;
      default: cnt_val = '0;
    endcase
  end

  // Output logic: registered outputs follow the state being entered.
  always_comb begin
    cs_no_d = '1;
    if ((state_d == SETUP) || (state_d == ACTIVE) || (state_d == HOLD)) begin
      cs_no_d = ~cs_sel_d;
    end
    ck_ena_d  = (state_d == ACTIVE) && ck_ena_i;
    active_d  = (state_d == ACTIVE);
    cs_err_d  = accept && !onehot;
    // Pulse appears in the first HOLD cycle; a close or abort pre-empts it.
    csm_exp_d = (state_q == ACTIVE) && !req_if.abort && !close_eff && csm_hit;
    cs_idx_d  = (accept && onehot) ? req_idx : cs_idx_q;
  end

  // State and output registers.
  always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      close_pend_q <= 1'b0;
      csm_cnt_q    <= '0;
      cs_no_q      <= '1;
      ck_ena_q     <= 1'b0;
      active_q     <= 1'b0;
      cs_err_q     <= 1'b0;
      csm_exp_q    <= 1'b0;
      cs_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      close_pend_q <= close_pend_d;
      csm_cnt_q    <= csm_cnt_d;
      cs_no_q      <= cs_no_d;
      ck_ena_q     <= ck_ena_d;
      active_q     <= active_d;
      cs_err_q     <= cs_err_d;
      csm_exp_q    <= csm_exp_d;
      cs_idx_q     <= cs_idx_d;
    end
  end

  // Transaction snapshot: only meaningful after an accept, so no reset.
  always_ff @(posedge tx_clk_90) begin
    timing_q <= timing_d;
    cs_sel_q <= cs_sel_d;
  end

  hyperbus_cs_sequencer_cnt #(
    .Width(CntMaxW)
  ) u_cnt (
    .tx_clk_90(tx_clk_90),
    .rst_ni   (rst_ni),
    .load_i   (cnt_load),
    .val_i    (cnt_val),
    .done_o   (cnt_done)
  );

  assign hyper_cs_no   = cs_no_q;
  assign ck_ena_o      = ck_ena_q;
  assign active_o      = active_q;
  assign cs_err_o      = cs_err_q;
  assign csm_expired_o = csm_exp_q;
  assign cs_idx_o      = cs_idx_q;

endmodule
